// File: rtl/instruction_assembler.sv
// Packs decoded RV32I fields into 32-bit machine words and streams them into
// instruction memory, one write per accepted bundle, during a start/finish load session.
module instruction_assembler #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              err
);

    localparam logic [6:0]        OP_R      = 7'b0110011;
    localparam logic [6:0]        OP_IMM    = 7'b0010011;
    localparam logic [6:0]        OP_LOAD   = 7'b0000011;
    localparam logic [6:0]        OP_JALR   = 7'b1100111;
    localparam logic [6:0]        OP_STORE  = 7'b0100011;
    localparam logic [6:0]        OP_BRANCH = 7'b1100011;
    localparam logic [6:0]        OP_LUI    = 7'b0110111;
    localparam logic [6:0]        OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]        OP_JAL    = 7'b1101111;
    localparam logic [31:0]       NOP_WORD  = 32'h0000_0013;
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] BASE_C    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    function automatic logic is_supported(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE,
            OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: is_supported = 1'b1;
            default:                             is_supported = 1'b0;
        endcase
    endfunction

    // Immediate bits outside each format's field are simply dropped; imm[0] never reaches B/J words.
    function automatic logic [31:0] encode(
        input logic [6:0]  op,
        input logic [4:0]  rd_i,
        input logic [2:0]  f3,
        input logic [4:0]  rs1_i,
        input logic [4:0]  rs2_i,
        input logic [6:0]  f7,
        input logic [31:0] im
    );
        case (op)
            OP_R:                       encode = {f7, rs2_i, rs1_i, f3, rd_i, op};
            OP_IMM, OP_LOAD, OP_JALR:   encode = {im[11:0], rs1_i, f3, rd_i, op};
            OP_STORE:                   encode = {im[11:5], rs2_i, rs1_i, f3, im[4:0], op};
            OP_BRANCH:                  encode = {im[12], im[10:5], rs2_i, rs1_i, f3,
                                                  im[4:1], im[11], op};
            OP_LUI, OP_AUIPC:           encode = {im[31:12], rd_i, op};
            OP_JAL:                     encode = {im[20], im[10:1], im[11], im[19:12], rd_i, op};
            default:                    encode = NOP_WORD;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                err_q, err_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_waddr_q, mem_waddr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                accept;

    assign in_ready  = (state_q == ST_LOAD) && (count_q < DEPTH_C);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != ST_IDLE);
    assign full      = (state_q == ST_FULL);
    assign count     = count_q;
    assign err       = err_q;
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ptr_d       = ptr_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                    ptr_d   = BASE_C;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = ptr_q;
                    mem_wdata_d = encode(opcode, rd, funct3, rs1, rs2, funct7, imm);
                    ptr_d       = ptr_q + PTR_ONE;
                    count_d     = count_q + CNT_ONE;
                    if (!is_supported(opcode)) begin
                        err_d = 1'b1;
                    end
                    if (count_d == DEPTH_C) begin
                        state_d = ST_FULL;
                    end
                end
                // A coincident accept still completes; finish only decides the next state.
                if (finish) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FULL: begin
                if (finish) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            ptr_q       <= BASE_C;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= BASE_C;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ptr_q       <= ptr_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: doc/instruction_assembler.md
Name: instruction_assembler

Overview:
Inverse of the field decoder. Accepts decoded RV32I instruction fields (opcode, rd, funct3, rs1, rs2, funct7, immediate) over a valid/ready stream, packs them into 32-bit machine words per the opcode's format, and writes them sequentially into instruction memory. Used by the bench and boot path to fill instruction memory from a field-level program description.

Parameters:
ADDR_W, 8, instruction memory word-address width
DEPTH, 256, max words written per load session (DEPTH <= 2**ADDR_W)
BASE_ADDR, 0, word address of the first write in a session

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; opens a load session (ignored unless IDLE)
finish  input  1  one-cycle pulse; closes session early (LOAD only)
in_valid  input  1  field bundle valid
in_ready  output  1  block can accept a bundle this cycle
opcode  input  7  instruction opcode
rd  input  5  destination register
funct3  input  3  funct3
rs1  input  5  source register 1
rs2  input  5  source register 2
funct7  input  7  funct7 (R-type only)
imm  input  32  immediate, byte offset, sign already applied
mem_we  output  1  instruction memory write enable
mem_waddr  output  ADDR_W  write word address
mem_wdata  output  32  encoded instruction
count  output  ADDR_W+1  words accepted in current session
busy  output  1  state != IDLE
full  output  1  state == FULL
err  output  1  sticky: an unsupported opcode was accepted this session

Behaviour:
- Reset, async, any state: state=IDLE; in_ready, mem_we, err, full, busy = 0; count=0; mem_waddr=BASE_ADDR; mem_wdata=0.
- FSM IDLE -> LOAD on start: count=0, err=0, write pointer=BASE_ADDR.
- LOAD -> FULL when an accept makes count == DEPTH. LOAD -> IDLE on finish.
- FULL -> IDLE on finish; start is ignored in FULL.
- in_ready = (state==LOAD) && (count < DEPTH). This is combinational from registered state. Accept = in_valid && in_ready.
- Latency 1. On the accept edge, mem_we=1, mem_wdata=encoded word and mem_waddr=pointer are registered. The pointer and count increment on the same edge. mem_we is high exactly one cycle per accept. Back-to-back accepts give back-to-back writes.
- Encoding, selected by opcode:
  - R, 0110011: {funct7, rs2, rs1, funct3, rd, opcode}
  - I, 0010011 / 0000011 / 1100111: {imm[11:0], rs1, funct3, rd, opcode}
  - S, 0100011: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B, 1100011: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U, 0110111 / 0010111: {imm[31:12], rd, opcode}
  - J, 1101111: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - Any other opcode: write NOP 0x00000013 and set err. The write still occupies a slot and count increments.
- Immediate bits outside each format's field are ignored, with no range check. For B and J, imm[0] is ignored.
- Pointer wraps modulo 2**ADDR_W and is never checked against DEPTH beyond the count limit.
- Simultaneous events:
  - finish with an accept in the same cycle: the accept completes (write occurs next cycle), then the state goes to IDLE.
  - start while in LOAD is ignored.
  - finish while in IDLE is ignored.
- Reset asserted mid-session: a pending write is dropped (mem_we forced 0 immediately); everything returns to reset values.
- count, err and full hold their values in IDLE after a session until the next start.

Test Plan:
- start; send add x3,x1,x2 (opcode 0110011, rd 3, f3 0, rs1 1, rs2 2, f7 0) -> next cycle mem_we=1, waddr=0, wdata=0x002081B3, count=1.
- Back-to-back bundles, one per cycle:
  - addi x1,x0,5 -> 0x00500093
  - sw x2,8(x1) -> 0x0020A423
  - beq x0,x0,8 -> 0x00000463
  - jal x1,16 -> 0x010000EF
  - lui x5,0x12345000 -> 0x123452B7
  - Required: waddr 0..4 in consecutive cycles, mem_we held high for 5 cycles.
- DEPTH=4, in_valid held high -> exactly 4 writes; in_ready drops the cycle after the 4th accept; full=1; after finish, state IDLE, count=4 retained.
- Opcode 1111111 accepted -> wdata=0x00000013, err=1 and stays set through later valid bundles until the next start.
- Assert reset in the cycle after an accept (mem_we pending) -> mem_we=0 immediately, in_ready=0, count=0. A later start resumes writing at BASE_ADDR.
- finish coincident with an accept -> that word is written next cycle; in_ready=0 in the following cycle; busy=0.
